// File: rtl/reservation_exec_unit_if.sv
// +----------------------------------------------------------------------+
// | reservation_exec_unit_if                                             |
// | Issue/completion bundle between a reservation station and its unit. |
// | Optional: EXEC_FLUSH_EN adds the flush strobe.                       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface reservation_exec_unit_if #(
    parameter int DW = 16
);
    logic          start;
    logic [1:0]    rsindex;
    logic [DW-1:0] rs1data;
    logic [DW-1:0] rs2data;
    logic [3:0]    func;
    logic [2:0]    rob_ind;
    logic [3:0]    rd;
`ifdef EXEC_FLUSH_EN
    logic          flush;
`endif
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic [2:0]    rob_out;
    logic [3:0]    rd_out;
    logic [1:0]    rsindex_out;
    logic          err;

    modport master (
        output start, rsindex, rs1data, rs2data, func, rob_ind, rd,
`ifdef EXEC_FLUSH_EN
        output flush,
`endif
        input  busy, done, result, rob_out, rd_out, rsindex_out, err
    );

    modport slave (
        input  start, rsindex, rs1data, rs2data, func, rob_ind, rd,
`ifdef EXEC_FLUSH_EN
        input  flush,
`endif
        output busy, done, result, rob_out, rd_out, rsindex_out, err
    );
endinterface

`default_nettype wire

// File: rtl/reservation_exec_unit.sv
// +----------------------------------------------------------------------+
// | reservation_exec_unit                                                |
// | Fixed-latency Tomasulo functional unit (add/sub/branch or mul/div).  |
// | Optional: EXEC_FLUSH_EN enables the in-flight flush input.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module reservation_exec_unit #(
    parameter int UNIT_KIND = 0,
    parameter int DW        = 16,
    parameter int ADD_LAT   = 2,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 6
) (
    input  wire logic              clk1,
    input  wire logic              rst_n,
    reservation_exec_unit_if.slave eu
);
    localparam logic [3:0] c_F_ADD = 4'b0000;
    localparam logic [3:0] c_F_SUB = 4'b0001;
    localparam logic [3:0] c_F_MUL = 4'b0010;
    localparam logic [3:0] c_F_DIV = 4'b0011;
    localparam logic [3:0] c_F_BEQ = 4'b0110;
    localparam logic [3:0] c_F_BNE = 4'b0111;

    localparam int c_MAX_LAT = (ADD_LAT > MUL_LAT) ?
                               ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT) :
                               ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
    localparam int c_CW = $clog2(c_MAX_LAT + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [3:0]      r_func;
    logic [2:0]      r_rob;
    logic [3:0]      r_rd;
    logic [1:0]      r_rsidx;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_result;
    logic [2:0]      r_rob_out;
    logic [3:0]      r_rd_out;
    logic [1:0]      r_rsidx_out;

    logic            w_flush;
    logic            w_accept;
    logic            w_finish;
    logic [DW-1:0]   w_res;
    logic            w_err;

    function automatic logic f_supported(input logic [3:0] f);
        if (UNIT_KIND == 0)
            return (f == c_F_ADD) || (f == c_F_SUB) || (f == c_F_BEQ) || (f == c_F_BNE);
        else
            return (f == c_F_MUL) || (f == c_F_DIV);
    endfunction

    // Anything this unit cannot execute still completes after one cycle
    // so the reservation-station slot is released.
    function automatic logic [c_CW-1:0] f_latency(input logic [3:0] f);
        if (!f_supported(f))   return c_CW'(1);
        else if (f == c_F_MUL) return c_CW'(MUL_LAT);
        else if (f == c_F_DIV) return c_CW'(DIV_LAT);
        else                   return c_CW'(ADD_LAT);
    endfunction

`ifdef EXEC_FLUSH_EN
    assign w_flush = eu.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && eu.start && !w_flush;
    assign w_finish = (r_state == S_BUSY) && (r_cnt == c_CW'(1)) && !w_flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)            w_state_nxt = S_BUSY;
            S_BUSY:  if (w_flush || w_finish) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        if (!f_supported(r_func)) begin
            w_err = 1'b1;
        end else begin
            case (r_func)
                c_F_ADD: w_res = r_a + r_b;
                c_F_SUB: w_res = r_a - r_b;
                c_F_MUL: w_res = r_a * r_b;
                c_F_DIV: begin
                    if (r_b == '0) begin
                        w_res = '1;
                        w_err = 1'b1;
                    end else begin
                        w_res = r_a / r_b;
                    end
                end
                c_F_BEQ: w_res = DW'(r_a == r_b);
                c_F_BNE: w_res = DW'(r_a != r_b);
                default: w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_func      <= '0;
            r_rob       <= '0;
            r_rd        <= '0;
            r_rsidx     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= '0;
            r_rob_out   <= '0;
            r_rd_out    <= '0;
            r_rsidx_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_a     <= eu.rs1data;
                r_b     <= eu.rs2data;
                r_func  <= eu.func;
                r_rob   <= eu.rob_ind;
                r_rd    <= eu.rd;
                r_rsidx <= eu.rsindex;
                r_cnt   <= f_latency(eu.func);
            end else if (r_state == S_BUSY) begin
                if (w_flush) begin
                    r_cnt <= '0;
                end else if (w_finish) begin
                    r_cnt       <= '0;
                    r_done      <= 1'b1;
                    r_result    <= w_res;
                    r_err       <= w_err;
                    r_rob_out   <= r_rob;
                    r_rd_out    <= r_rd;
                    r_rsidx_out <= r_rsidx;
                end else begin
                    r_cnt <= r_cnt - c_CW'(1);
                end
            end
        end
    end

    assign eu.busy        = (r_state == S_BUSY);
    assign eu.done        = r_done;
    assign eu.result      = r_result;
    assign eu.err         = r_err;
    assign eu.rob_out     = r_rob_out;
    assign eu.rd_out      = r_rd_out;
    assign eu.rsindex_out = r_rsidx_out;
endmodule

`default_nettype wire

// File: tb/tb_reservation_exec_unit.sv
// +----------------------------------------------------------------------+
// | tb_reservation_exec_unit                                             |
// | Drives an add/sub/branch unit and a mul/div unit with the same issue |
// | stream and compares both against an arithmetic reference model.     |
// | Optional: EXEC_FLUSH_EN exercises the flush input.                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reservation_exec_unit;
    localparam int c_DW      = 16;
    localparam int c_ADD_LAT = 2;
    localparam int c_MUL_LAT = 4;
    localparam int c_DIV_LAT = 6;

    logic clk1 = 1'b0;
    logic rst_n;
    always #5 clk1 = ~clk1;

    logic        start_s;
    logic [1:0]  idx_s;
    logic [15:0] a_s;
    logic [15:0] b_s;
    logic [3:0]  func_s;
    logic [2:0]  rob_s;
    logic [3:0]  rd_s;
    logic        flush_s;

    reservation_exec_unit_if #(.DW(c_DW)) u_if0 ();
    reservation_exec_unit_if #(.DW(c_DW)) u_if1 ();

    assign u_if0.start = start_s;   assign u_if1.start = start_s;
    assign u_if0.rsindex = idx_s;   assign u_if1.rsindex = idx_s;
    assign u_if0.rs1data = a_s;     assign u_if1.rs1data = a_s;
    assign u_if0.rs2data = b_s;     assign u_if1.rs2data = b_s;
    assign u_if0.func = func_s;     assign u_if1.func = func_s;
    assign u_if0.rob_ind = rob_s;   assign u_if1.rob_ind = rob_s;
    assign u_if0.rd = rd_s;         assign u_if1.rd = rd_s;
`ifdef EXEC_FLUSH_EN
    assign u_if0.flush = flush_s;   assign u_if1.flush = flush_s;
`endif

    reservation_exec_unit #(.UNIT_KIND(0), .DW(c_DW), .ADD_LAT(c_ADD_LAT),
                            .MUL_LAT(c_MUL_LAT), .DIV_LAT(c_DIV_LAT))
        u_dut0 (.clk1(clk1), .rst_n(rst_n), .eu(u_if0));
    reservation_exec_unit #(.UNIT_KIND(1), .DW(c_DW), .ADD_LAT(c_ADD_LAT),
                            .MUL_LAT(c_MUL_LAT), .DIV_LAT(c_DIV_LAT))
        u_dut1 (.clk1(clk1), .rst_n(rst_n), .eu(u_if1));

    logic        busy_v [2];
    logic        done_v [2];
    logic        err_v  [2];
    logic [15:0] res_v  [2];
    logic [2:0]  rob_v  [2];
    logic [3:0]  rd_v   [2];
    logic [1:0]  idx_v  [2];

    assign busy_v[0] = u_if0.busy;  assign busy_v[1] = u_if1.busy;
    assign done_v[0] = u_if0.done;  assign done_v[1] = u_if1.done;
    assign err_v[0]  = u_if0.err;   assign err_v[1]  = u_if1.err;
    assign res_v[0]  = u_if0.result; assign res_v[1] = u_if1.result;
    assign rob_v[0]  = u_if0.rob_out; assign rob_v[1] = u_if1.rob_out;
    assign rd_v[0]   = u_if0.rd_out; assign rd_v[1]  = u_if1.rd_out;
    assign idx_v[0]  = u_if0.rsindex_out; assign idx_v[1] = u_if1.rsindex_out;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what each unit kind must produce, straight from the ISA rules.
    function automatic void model(input int kind, input logic [3:0] f,
                                  input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic e, output int lat);
        int     ia = int'(a);
        int     ib = int'(b);
        bit     sup;
        longint prod;
        sup = (kind == 0) ? (f == 0 || f == 1 || f == 6 || f == 7) : (f == 2 || f == 3);
        r = 16'h0; e = 1'b0; lat = 1;
        if (!sup) begin
            e = 1'b1;
        end else begin
            case (f)
                4'd0: begin r = 16'((ia + ib) % 65536); lat = c_ADD_LAT; end
                4'd1: begin r = 16'((ia - ib + 65536) % 65536); lat = c_ADD_LAT; end
                4'd6: begin r = (ia == ib) ? 16'd1 : 16'd0; lat = c_ADD_LAT; end
                4'd7: begin r = (ia != ib) ? 16'd1 : 16'd0; lat = c_ADD_LAT; end
                4'd2: begin
                    prod = longint'(ia) * longint'(ib);
                    r = 16'(prod % 65536); lat = c_MUL_LAT;
                end
                default: begin
                    lat = c_DIV_LAT;
                    if (ib == 0) begin r = 16'hFFFF; e = 1'b1; end
                    else r = 16'(ia / ib);
                end
            endcase
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_busy"}, 32'(busy_v[k]), 0);
            check({tag, "_done"}, 32'(done_v[k]), 0);
            check({tag, "_err"},  32'(err_v[k]), 0);
            check({tag, "_res"},  32'(res_v[k]), 0);
            check({tag, "_rob"},  32'(rob_v[k]), 0);
            check({tag, "_rd"},   32'(rd_v[k]), 0);
            check({tag, "_idx"},  32'(idx_v[k]), 0);
        end
    endtask

    // Issues one op to both units; returns on the negedge where the slower
    // unit shows done, so a following call re-issues on the very next edge.
    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] rob, input logic [3:0] rdv, input logic [1:0] idx,
                         input bit spam);
        logic [15:0] er [2];
        logic        ee [2];
        int          el [2];
        int          seen [2];
        int          pulses [2];
        for (int k = 0; k < 2; k++) begin
            model(k, f, a, b, er[k], ee[k], el[k]);
            seen[k] = 0; pulses[k] = 0;
        end
        func_s = f; a_s = a; b_s = b; rob_s = rob; rd_s = rdv; idx_s = idx; start_s = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        for (int k = 0; k < 2; k++) begin
            check("busy_after_start", 32'(busy_v[k]), 1);
            check("done_after_start", 32'(done_v[k]), 0);
        end
        if (spam) begin
            func_s = 4'd0; a_s = 16'd1; b_s = 16'd1; rob_s = 3'd7; rd_s = 4'd15; idx_s = 2'd2;
        end else begin
            start_s = 1'b0;
            func_s = 4'($urandom); a_s = 16'($urandom); b_s = 16'($urandom);
            rob_s = 3'($urandom); rd_s = 4'($urandom); idx_s = 2'($urandom);
        end
        for (int n = 1; n <= 12 && !(seen[0] > 0 && seen[1] > 0); n++) begin
            @(negedge clk1);
            if (n == 1) start_s = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (done_v[k]) begin
                    pulses[k]++;
                    if (seen[k] == 0) begin
                        seen[k] = n;
                        check("latency", 32'(n), 32'(el[k]));
                        check("result",  32'(res_v[k]), 32'(er[k]));
                        check("err",     32'(err_v[k]), 32'(ee[k]));
                        check("rob_out", 32'(rob_v[k]), 32'(rob));
                        check("rd_out",  32'(rd_v[k]), 32'(rdv));
                        check("rsidx",   32'(idx_v[k]), 32'(idx));
                        check("busy_at_done", 32'(busy_v[k]), 0);
                    end
                end else if (seen[k] > 0) begin
                    check("result_hold", 32'(res_v[k]), 32'(er[k]));
                    check("idle_after_done", 32'(busy_v[k]), 0);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            check("done_seen", 32'(seen[k] > 0), 1);
            check("pulses", 32'(pulses[k]), 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start_s = 1'b0; flush_s = 1'b0;
        idx_s = '0; a_s = '0; b_s = '0; func_s = '0; rob_s = '0; rd_s = '0;
        repeat (2) @(negedge clk1);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk1);

        issue(4'd0, 16'hFFFF, 16'd2, 3'd5, 4'd3, 2'd1, 1'b0);
        issue(4'd1, 16'd3, 16'd5, 3'd1, 4'd4, 2'd0, 1'b0);
        issue(4'd6, 16'd7, 16'd7, 3'd2, 4'd5, 2'd2, 1'b0);
        issue(4'd7, 16'd7, 16'd7, 3'd3, 4'd6, 2'd1, 1'b0);
        issue(4'd2, 16'd300, 16'd300, 3'd4, 4'd7, 2'd0, 1'b0);
        issue(4'd3, 16'd100, 16'd7, 3'd6, 4'd8, 2'd2, 1'b0);
        issue(4'd3, 16'd9, 16'd0, 3'd7, 4'd9, 2'd1, 1'b0);
        issue(4'd3, 16'd100, 16'd7, 3'd1, 4'd2, 2'd0, 1'b1);
        issue(4'd2, 16'd300, 16'd300, 3'd5, 4'd1, 2'd2, 1'b1);
        issue(4'd4, 16'd12, 16'd34, 3'd2, 4'd10, 2'd1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  f;
            logic [15:0] b;
            int          pick;
            pick = int'($urandom_range(0, 9));
            case (pick)
                0: f = 4'd0; 1: f = 4'd1; 2: f = 4'd2;
                3: f = 4'd3; 4: f = 4'd6; 5: f = 4'd7;
                default: f = 4'($urandom_range(0, 15));
            endcase
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            issue(f, 16'($urandom), b, 3'($urandom), 4'($urandom), 2'($urandom_range(0, 2)),
                  bit'($urandom_range(0, 3) == 0));
        end

        // Reset while both units hold a MUL 3*5 in flight.
        @(negedge clk1);
        func_s = 4'd2; a_s = 16'd3; b_s = 16'd5; rob_s = 3'd6; rd_s = 4'd12; idx_s = 2'd2;
        start_s = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        start_s = 1'b0;
        check("busy_before_rst", 32'(busy_v[1]), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk1);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk1);
            check("no_done_after_rst0", 32'(done_v[0]), 0);
            check("no_done_after_rst1", 32'(done_v[1]), 0);
        end

`ifdef EXEC_FLUSH_EN
        func_s = 4'd3; a_s = 16'd100; b_s = 16'd7; rob_s = 3'd3; rd_s = 4'd3; idx_s = 2'd1;
        start_s = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        start_s = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        check("busy_before_flush", 32'(busy_v[1]), 1);
        flush_s = 1'b1;
        @(negedge clk1);
        flush_s = 1'b0;
        check("busy_after_flush", 32'(busy_v[1]), 0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk1);
            check("no_done_after_flush", 32'(done_v[1]), 0);
        end
        flush_s = 1'b1; start_s = 1'b1;
        @(negedge clk1);
        flush_s = 1'b0; start_s = 1'b0;
        check("flush_beats_start0", 32'(busy_v[0]), 0);
        check("flush_beats_start1", 32'(busy_v[1]), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
